// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multiplier/divider: latches requests, issues a start pulse,
// waits for the selected unit's RDY (or the watchdog) and returns a one-cycle result pulse.
module multdiv_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CTW     = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             mult_start,
  output logic             div_start,
  output logic [WIDTH-1:0] unit_A,
  output logic [WIDTH-1:0] unit_B,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_exception,
  input  logic             mult_RDY,
  input  logic [WIDTH-1:0] div_result,
  input  logic             div_exception,
  input  logic             div_RDY,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic             req_dropped
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;              // 1 = divide
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             pv_q, pv_d, pop_q, pop_d;
  logic [WIDTH-1:0] pa_q, pa_d, pb_q, pb_d;
  logic [CTW-1:0]   wd_q, wd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d, drop_q, drop_d;
  logic             mult_start_q, mult_start_d, div_start_q, div_start_d;
  logic             rdy_q, busy_q;
  logic             req, load, load_div;
  logic [WIDTH-1:0] load_a, load_b;

  assign req = ctrl_MULT | ctrl_DIV;

  // Next-state, pending-slot and result logic
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    pv_d         = pv_q;
    pop_d        = pop_q;
    pa_d         = pa_q;
    pb_d         = pb_q;
    wd_d         = wd_q;
    res_d        = res_q;
    exc_d        = exc_q;
    drop_d       = drop_q;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    load         = 1'b0;
    load_div     = pop_q;
    load_a       = pa_q;
    load_b       = pb_q;

    if (ctrl_MULT && ctrl_DIV) drop_d = 1'b1;

    // Requests arriving while busy (DONE included) go to the slot or are lost
    if (req && state_q != S_IDLE) begin
      if (pv_q) begin
        drop_d = 1'b1;
      end else begin
        pv_d  = 1'b1;
        pop_d = ctrl_DIV;
        pa_d  = data_operandA;
        pb_d  = data_operandB;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pv_q) begin
          load = 1'b1;
          pv_d = req;
          if (req) begin
            pop_d = ctrl_DIV;
            pa_d  = data_operandA;
            pb_d  = data_operandB;
          end
        end else if (req) begin
          load     = 1'b1;
          load_div = ctrl_DIV;
          load_a   = data_operandA;
          load_b   = data_operandB;
        end
      end
      S_ISSUE: begin
        if (op_q && b_q == WIDTH'(0)) begin
          state_d = S_DONE;
          res_d   = WIDTH'(0);
          exc_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_d = wd_q + CTW'(1);
        if (op_q ? div_RDY : mult_RDY) begin
          state_d = S_DONE;
          res_d   = op_q ? div_result : mult_result;
          exc_d   = op_q ? div_exception : mult_exception;
        end else if (wd_q == CTW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          res_d   = WIDTH'(0);
          exc_d   = 1'b1;
        end
      end
      S_DONE: begin
        if (pv_q) begin
          load = 1'b1;
          pv_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Entering ISSUE: latch operands, clear watchdog, arm the start pulse
    if (load) begin
      state_d      = S_ISSUE;
      op_d         = load_div;
      a_d          = load_a;
      b_d          = load_b;
      wd_d         = CTW'(0);
      mult_start_d = ~load_div;
      div_start_d  = load_div && (load_b != WIDTH'(0));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      pv_q         <= 1'b0;
      pop_q        <= 1'b0;
      pa_q         <= '0;
      pb_q         <= '0;
      wd_q         <= '0;
      res_q        <= '0;
      exc_q        <= 1'b0;
      drop_q       <= 1'b0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      pv_q         <= pv_d;
      pop_q        <= pop_d;
      pa_q         <= pa_d;
      pb_q         <= pb_d;
      wd_q         <= wd_d;
      res_q        <= res_d;
      exc_q        <= exc_d;
      drop_q       <= drop_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      rdy_q        <= (state_d == S_DONE);
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign mult_start     = mult_start_q;
  assign div_start      = div_start_q;
  assign unit_A         = a_q;
  assign unit_B         = b_q;
  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
  assign req_dropped    = drop_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: expected {exception,result} pairs are queued when a
// request is driven and popped whenever the DUT raises data_resultRDY.
module tb_multdiv_ctrl;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ctrl_MULT, ctrl_DIV;
  logic [WIDTH-1:0] data_operandA, data_operandB;
  logic             mult_start, div_start;
  logic [WIDTH-1:0] unit_A, unit_B;
  logic [WIDTH-1:0] mult_result, div_result;
  logic             mult_exception, mult_RDY, div_exception, div_RDY;
  logic [WIDTH-1:0] data_result;
  logic             data_exception, data_resultRDY, busy, req_dropped;

  multdiv_ctrl #(.WIDTH(32), .TIMEOUT(40), .CTW(6)) dut (
    .clk(clk), .reset_n(reset_n), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .mult_start(mult_start), .div_start(div_start), .unit_A(unit_A), .unit_B(unit_B),
    .mult_result(mult_result), .mult_exception(mult_exception), .mult_RDY(mult_RDY),
    .div_result(div_result), .div_exception(div_exception), .div_RDY(div_RDY),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy), .req_dropped(req_dropped)
  );

  always #5 clk = ~clk;

  logic [WIDTH:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int mult_cnt = 0;
  int lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any completion pulse
  task automatic tick();
    logic [WIDTH:0] e;
    @(negedge clk);
    if (mult_start === 1'b1) mult_cnt++;
    if (data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rdy_unexpected", 64'(data_resultRDY), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_result", 64'(data_result), 64'(e[WIDTH-1:0]));
        chk("sb_exception", 64'(data_exception), 64'(e[WIDTH]));
      end
    end
  endtask

  task automatic wait_rdy(input string tag, input int budget, output int n);
    n = 0;
    while (data_resultRDY !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(data_resultRDY), 64'd1);
  endtask

  task automatic request(input logic m, input logic d, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
  endtask

  initial begin
    int mc;
    reset_n = 1'b0;
    request(1'b0, 1'b0, '0, '0);
    mult_result = '0; mult_exception = 1'b0; mult_RDY = 1'b0;
    div_result = '0; div_exception = 1'b0; div_RDY = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy", 64'(data_resultRDY), 64'd0);
    chk("rst_result", 64'(data_result), 64'd0);
    chk("rst_dropped", 64'(req_dropped), 64'd0);
    chk("rst_starts", 64'({mult_start, div_start}), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: MULT 6*7 = 42
    request(1'b1, 1'b0, 32'd6, 32'd7); sb.push_back({1'b0, 32'd42});
    tick(); request(1'b0, 1'b0, '0, '0);
    chk("t1_mult_start", 64'(mult_start), 64'd1);
    chk("t1_div_start", 64'(div_start), 64'd0);
    chk("t1_unit_ab", 64'({unit_A, unit_B}), {32'd6, 32'd7});
    tick();
    chk("t1_start_single", 64'(mult_start), 64'd0);
    repeat (15) tick();
    mult_result = 32'd42; mult_RDY = 1'b1;
    wait_rdy("t1_rdy", 5, lat);
    chk("t1_rdy_latency", 64'(lat), 64'd1);
    mult_RDY = 1'b0;
    tick();
    chk("t1_busy_falls", 64'(busy), 64'd0);
    chk("t1_result_held", 64'(data_result), 64'd42);

    // 2: DIV -20/3 -> -6, stray multiplier RDY ignored
    mc = mult_cnt;
    request(1'b0, 1'b1, 32'hFFFF_FFEC, 32'd3); sb.push_back({1'b0, 32'hFFFF_FFFA});
    tick(); request(1'b0, 1'b0, '0, '0);
    chk("t2_div_start", 64'(div_start), 64'd1);
    tick();
    mult_result = 32'd99; mult_RDY = 1'b1;
    tick(); mult_RDY = 1'b0;
    chk("t2_ignore_mult_rdy", 64'(data_resultRDY), 64'd0);
    div_result = 32'hFFFF_FFFA; div_RDY = 1'b1;
    wait_rdy("t2_rdy", 5, lat);
    div_RDY = 1'b0;
    chk("t2_no_mult_start", 64'(mult_cnt - mc), 64'd0);
    tick();

    // 3: DIV by zero short-circuit
    request(1'b0, 1'b1, 32'd5, 32'd0); sb.push_back({1'b1, 32'd0});
    tick(); request(1'b0, 1'b0, '0, '0);
    chk("t3_no_div_start", 64'(div_start), 64'd0);
    chk("t3_not_yet", 64'(data_resultRDY), 64'd0);
    tick();
    chk("t3_rdy_t2", 64'(data_resultRDY), 64'd1);
    tick();

    // 4: queued MULT behind a DIV, third request dropped
    request(1'b0, 1'b1, 32'd100, 32'd7); sb.push_back({1'b0, 32'd14});
    tick(); request(1'b0, 1'b0, '0, '0);
    repeat (4) tick();
    request(1'b1, 1'b0, 32'd2, 32'd3); sb.push_back({1'b0, 32'd6});
    tick();
    request(1'b1, 1'b0, 32'd9, 32'd9);
    tick(); request(1'b0, 1'b0, '0, '0);
    chk("t4_dropped", 64'(req_dropped), 64'd1);
    chk("t4_unit_a_stable", 64'(unit_A), 64'd100);
    div_result = 32'd14; div_RDY = 1'b1;
    wait_rdy("t4_div_rdy", 5, lat);
    div_RDY = 1'b0;
    tick();
    chk("t4_queued_start", 64'(mult_start), 64'd1);
    chk("t4_queued_ab", 64'({unit_A, unit_B}), {32'd2, 32'd3});
    tick();
    mult_result = 32'd6; mult_RDY = 1'b1;
    wait_rdy("t4_mult_rdy", 5, lat);
    mult_RDY = 1'b0;
    tick();

    // 5: watchdog timeout
    request(1'b1, 1'b0, 32'd1, 32'd1); sb.push_back({1'b1, 32'd0});
    tick(); request(1'b0, 1'b0, '0, '0);
    tick();
    wait_rdy("t5_timeout_rdy", 60, lat);
    chk("t5_timeout_latency", 64'(lat), 64'd40);
    tick();
    chk("t5_idle", 64'(busy), 64'd0);

    // 6: async reset mid-WAIT, then stale RDY
    request(1'b0, 1'b1, 32'd50, 32'd5);
    tick(); request(1'b0, 1'b0, '0, '0);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_outs", 64'({data_result, unit_A}), 64'd0);
    chk("t6_dropped", 64'(req_dropped), 64'd0);
    tick(); reset_n = 1'b1;
    div_result = 32'd10; div_RDY = 1'b1;
    tick(); div_RDY = 1'b0;
    tick();
    chk("t6_no_stale_rdy", 64'(data_resultRDY), 64'd0);
    chk("t6_still_idle", 64'(busy), 64'd0);

    // 7: simultaneous MULT+DIV -> DIV wins, drop flagged
    request(1'b1, 1'b1, 32'd12, 32'd4); sb.push_back({1'b0, 32'd3});
    tick(); request(1'b0, 1'b0, '0, '0);
    chk("t7_div_wins", 64'({mult_start, div_start}), 64'd1);
    chk("t7_dropped", 64'(req_dropped), 64'd1);
    tick();
    div_result = 32'd3; div_RDY = 1'b1;
    wait_rdy("t7_rdy", 5, lat);
    div_RDY = 1'b0;
    tick(); tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
